// File: rtl/npc_pkg.sv
// Shared types and helpers for the next-PC predictor: counter encodings, BTB entry layout.
// BTB entry fields are sized for XLEN_DEFAULT; tags are stored zero-extended.
package npc_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   typedef struct packed {
      logic                    valid;
      logic [XLEN_DEFAULT-1:0] tag;
      logic [XLEN_DEFAULT-1:0] target;
      ctr_t                    ctr;
   } btb_entry_t;

   function automatic int idx_w(input int entries);
      return $clog2(entries);
   endfunction

   function automatic int tag_w(input int xlen, input int entries);
      return xlen - $clog2(entries) - 2;
   endfunction

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational on the fetch word address; update comes from EX-resolved branches.
module npc_btb
   import npc_pkg::*;
#(
   parameter int XLEN        = XLEN_DEFAULT,
   parameter int BTB_ENTRIES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-3:0] lookup_word,
   output logic            hit_taken,
   output logic [XLEN-1:0] hit_target,
   input  logic            upd_en,
   input  logic [XLEN-3:0] upd_word,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target
);

   localparam int IDX_W = idx_w(BTB_ENTRIES);
   localparam int TAG_W = tag_w(XLEN, BTB_ENTRIES);
   localparam int FW    = XLEN_DEFAULT;

   btb_entry_t tbl [BTB_ENTRIES];

   logic [IDX_W-1:0] l_idx, u_idx;
   logic [TAG_W-1:0] l_tag, u_tag;
   btb_entry_t       l_ent, u_ent;
   logic             u_hit;

   assign l_idx = lookup_word[IDX_W-1:0];
   assign l_tag = lookup_word[XLEN-3:IDX_W];
   assign u_idx = upd_word[IDX_W-1:0];
   assign u_tag = upd_word[XLEN-3:IDX_W];

   // Lookup reads the array before any same-cycle write lands.
   assign l_ent      = tbl[l_idx];
   assign hit_taken  = l_ent.valid && (l_ent.tag == FW'(l_tag)) && l_ent.ctr[1];
   assign hit_target = l_ent.target[XLEN-1:0];

   assign u_ent = tbl[u_idx];
   assign u_hit = u_ent.valid && (u_ent.tag == FW'(u_tag));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BTB_ENTRIES; i++) tbl[i] <= '0;
      end else if (upd_en) begin
         if (u_hit) begin
            if (upd_taken) begin
               tbl[u_idx].ctr    <= (u_ent.ctr == ST) ? ST : ctr_t'(u_ent.ctr + 2'd1);
               tbl[u_idx].target <= FW'(upd_target);
            end else begin
               tbl[u_idx].ctr    <= (u_ent.ctr == SNT) ? SNT : ctr_t'(u_ent.ctr - 2'd1);
            end
         end else if (upd_taken) begin
            tbl[u_idx] <= '{valid: 1'b1, tag: FW'(u_tag), target: FW'(upd_target), ctr: WT};
         end
      end
   end

endmodule

// File: rtl/npc_predict_unit.sv
// Fetch PC register with next-PC priority, EX misprediction recovery and flush generation.
// Define NPC_BTB_EN to add the branch target buffer; otherwise fetch always falls through.
module npc_predict_unit
   import npc_pkg::*;
#(
   parameter int              XLEN        = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int              BTB_ENTRIES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_f,
   input  logic            jal_d,
   input  logic [XLEN-1:0] jal_target_d,
   input  logic            br_e,
   input  logic            br_taken_e,
   input  logic [XLEN-1:0] br_target_e,
   input  logic            jalr_e,
   input  logic [XLEN-1:0] jalr_target_e,
   input  logic [XLEN-1:0] pc_e,
   input  logic            pred_taken_e,
   input  logic [XLEN-1:0] pred_target_e,
   output logic [XLEN-1:0] pc_f,
   output logic            pred_taken_f,
   output logic [XLEN-1:0] pred_target_f,
   output logic            flush_d,
   output logic            flush_e
);

   logic [XLEN-1:0] fall_f, fall_e, fix_target, pc_next;
   logic            mispredict_e, redirect_e, jal_go;

   assign fall_f = pc_f + XLEN'(4);
   assign fall_e = pc_e + XLEN'(4);

`ifdef NPC_BTB_EN
   logic            btb_taken;
   logic [XLEN-1:0] btb_target;

   npc_btb #(.XLEN(XLEN), .BTB_ENTRIES(BTB_ENTRIES)) u_btb (
      .clk         (clk),
      .rst_n       (rst_n),
      .lookup_word (pc_f[XLEN-1:2]),
      .hit_taken   (btb_taken),
      .hit_target  (btb_target),
      .upd_en      (br_e),
      .upd_word    (pc_e[XLEN-1:2]),
      .upd_taken   (br_taken_e),
      .upd_target  (br_target_e)
   );

   assign pred_taken_f  = btb_taken;
   assign pred_target_f = btb_taken ? btb_target : fall_f;
`else
   assign pred_taken_f  = 1'b0;
   assign pred_target_f = fall_f;
`endif

   // A taken branch is only correct if both direction and target matched the prediction.
   assign mispredict_e = br_e & ((br_taken_e != pred_taken_e) |
                                 (br_taken_e & (br_target_e != pred_target_e)));
   assign redirect_e   = mispredict_e | jalr_e;
   assign fix_target   = jalr_e ? jalr_target_e : (br_taken_e ? br_target_e : fall_e);
   assign jal_go       = jal_d & ~stall_f;

   assign flush_d = redirect_e | jal_go;
   assign flush_e = redirect_e;

   always_comb begin
      pc_next = pred_target_f;
      if (redirect_e)   pc_next = fix_target;
      else if (jal_go)  pc_next = jal_target_d;
      else if (stall_f) pc_next = pc_f;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_f <= RESET_PC;
      else        pc_f <= pc_next;
   end

endmodule

// File: tb/tb_npc_predict_unit.sv
// Scoreboard bench for npc_predict_unit: directed scenarios then randomized traffic
// against an array-based reference model; works with or without NPC_BTB_EN.
module tb_npc_predict_unit;

   localparam int          ENT = 16;
   localparam logic [31:0] RPC = 32'h100;
`ifdef NPC_BTB_EN
   localparam bit BTB_ON = 1'b1;
`else
   localparam bit BTB_ON = 1'b0;
`endif

   logic        clk = 1'b0, rst_n = 1'b1;
   logic        stall_f = 0, jal_d = 0, br_e = 0, br_taken_e = 0, jalr_e = 0, pred_taken_e = 0;
   logic [31:0] jal_target_d = 0, br_target_e = 0, jalr_target_e = 0, pc_e = 0, pred_target_e = 0;
   logic [31:0] pc_f, pred_target_f;
   logic        pred_taken_f, flush_d, flush_e;

   always #5 clk = ~clk;

   npc_predict_unit #(.XLEN(32), .RESET_PC(RPC), .BTB_ENTRIES(ENT)) dut (
      .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .jal_d(jal_d), .jal_target_d(jal_target_d),
      .br_e(br_e), .br_taken_e(br_taken_e), .br_target_e(br_target_e), .jalr_e(jalr_e),
      .jalr_target_e(jalr_target_e), .pc_e(pc_e), .pred_taken_e(pred_taken_e),
      .pred_target_e(pred_target_e), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
      .pred_target_f(pred_target_f), .flush_d(flush_d), .flush_e(flush_e)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ptgt;
      logic        pt;
      logic        fd;
      logic        fe;
   } exp_t;

   exp_t q[$];
   int   checks = 0, errors = 0;

   // Reference state: fetch PC plus a table of branches keyed by word index.
   logic [31:0] m_pc;
   bit          m_v   [ENT];
   logic [31:0] m_br  [ENT];
   logic [31:0] m_tgt [ENT];
   int          m_ctr [ENT];

   function automatic int idx_of(logic [31:0] a);
      return int'((a / 4) % ENT);
   endfunction

   function automatic bit m_hit(logic [31:0] a);
      int i = idx_of(a);
      return BTB_ON && m_v[i] && (m_br[i] / (4 * ENT) == a / (4 * ENT));
   endfunction

   function automatic bit m_ptaken(logic [31:0] a);
      return m_hit(a) && (m_ctr[idx_of(a)] >= 2);
   endfunction

   function automatic logic [31:0] m_ptarget(logic [31:0] a);
      logic [31:0] f = a + 32'd4;
      return m_ptaken(a) ? m_tgt[idx_of(a)] : f;
   endfunction

   task automatic model_reset();
      m_pc = RPC;
      for (int i = 0; i < ENT; i++) begin
         m_v[i] = 0; m_br[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
      end
   endtask

   // Push expected outputs for the current cycle, then advance the model across the edge.
   task automatic model_cycle();
      exp_t        e;
      bit          mis, red;
      logic [31:0] fix, nxt, fe4;
      int          i;
      e.pc   = m_pc;
      e.pt   = m_ptaken(m_pc);
      e.ptgt = m_ptarget(m_pc);
      mis    = br_e && ((br_taken_e != pred_taken_e) || (br_taken_e && br_target_e != pred_target_e));
      red    = mis || jalr_e;
      fe4    = pc_e + 32'd4;
      fix    = jalr_e ? jalr_target_e : (br_taken_e ? br_target_e : fe4);
      e.fd   = red || (jal_d && !stall_f);
      e.fe   = red;
      q.push_back(e);
      if (red)                  nxt = fix;
      else if (jal_d && !stall_f) nxt = jal_target_d;
      else if (stall_f)         nxt = m_pc;
      else                      nxt = e.ptgt;
      if (BTB_ON && br_e) begin
         i = idx_of(pc_e);
         if (m_hit(pc_e)) begin
            if (br_taken_e) begin
               m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
               m_tgt[i] = br_target_e;
            end else begin
               m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
         end else if (br_taken_e) begin
            m_v[i] = 1; m_br[i] = pc_e; m_tgt[i] = br_target_e; m_ctr[i] = 2;
         end
      end
      m_pc = nxt;
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check("pc_f", pc_f, e.pc);
         check("pred_taken_f", 32'(pred_taken_f), 32'(e.pt));
         check("pred_target_f", pred_target_f, e.ptgt);
         check("flush_d", 32'(flush_d), 32'(e.fd));
         check("flush_e", 32'(flush_e), 32'(e.fe));
      end
   end

   task automatic zero_inputs();
      stall_f = 0; jal_d = 0; jal_target_d = 0; br_e = 0; br_taken_e = 0; br_target_e = 0;
      jalr_e = 0; jalr_target_e = 0; pc_e = 0; pred_taken_e = 0; pred_target_e = 0;
   endtask

   task automatic drive(bit st, bit jl, logic [31:0] jt, bit br, bit tk, logic [31:0] bt,
                        bit jr, logic [31:0] jrt, logic [31:0] pe, bit pte, logic [31:0] pge);
      @(posedge clk); #1;
      stall_f = st; jal_d = jl; jal_target_d = jt; br_e = br; br_taken_e = tk; br_target_e = bt;
      jalr_e = jr; jalr_target_e = jrt; pc_e = pe; pred_taken_e = pte; pred_target_e = pge;
      model_cycle();
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Branch in EX carrying whatever the model would have predicted for it at fetch.
   task automatic branch(logic [31:0] pe, bit tk, logic [31:0] bt);
      drive(0, 0, 0, 1, tk, bt, 0, 0, pe, m_ptaken(pe), m_ptarget(pe));
   endtask

   // Assert reset mid-cycle, check the asynchronous effect, release before the monitor edge.
   task automatic pulse_reset();
      @(posedge clk); #1;
      zero_inputs();
      rst_n = 1'b0;
      #1;
      check("async_reset_pc", pc_f, RPC);
      check("async_reset_pred", 32'(pred_taken_f), 32'd0);
      check("async_reset_ptgt", pred_target_f, RPC + 32'd4);
      check("async_reset_flush", 32'({flush_d, flush_e}), 32'd0);
      #2;
      rst_n = 1'b1;
      model_reset();
      model_cycle();
   endtask

   logic [31:0] pool [8] = '{32'h10, 32'h14, 32'h40, 32'h20, 32'h410, 32'h100, 32'h3c, 32'h80};

   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      pulse_reset();
      idle(); idle(); idle();

      branch(32'h10, 1, 32'h40);
      drive(0, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      branch(32'h10, 1, 32'h40);
      branch(32'h10, 0, 32'h40);
      idle();

      drive(1, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 1, 32'h200, 32'h50, 0, 0);
      drive(0, 1, 32'h80, 0, 0, 0, 1, 32'h300, 32'h54, 0, 0);
      idle();

      drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(); idle();
      pulse_reset();
      idle();

      for (int n = 0; n < 2000; n++) begin
         logic [31:0] pe;
         bit          pte;
         logic [31:0] pge;
         pe = pool[$urandom_range(0, 7)];
         if ($urandom_range(0, 1) == 1) begin
            pte = m_ptaken(pe); pge = m_ptarget(pe);
         end else begin
            pte = 1'($urandom_range(0, 1)); pge = pool[$urandom_range(0, 7)];
         end
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, pool[$urandom_range(0, 7)],
               $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
               $urandom_range(0, 9) == 0, pool[$urandom_range(0, 7)], pe, pte, pge);
         if (n == 1000) pulse_reset();
      end
      idle();
      @(posedge clk); #1;
      zero_inputs();
      @(posedge clk);
      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
